// File: rtl/usb_vec_bridge_if.sv
// Byte-pipeline interface between usb_vec_bridge and the USB-UART core.
//   uart_in_*  : bridge -> USB TX pipeline (data/valid out, ready back)
//   uart_out_* : USB RX pipeline -> bridge (data/valid in, ready back)
// modport master : the bridge side
// modport slave  : the USB pipeline side
interface usb_vec_bridge_if;
  logic [7:0] uart_in_data;
  logic       uart_in_valid;
  logic       uart_in_ready;
  logic [7:0] uart_out_data;
  logic       uart_out_valid;
  logic       uart_out_ready;

  modport master (
    output uart_in_data,
    output uart_in_valid,
    input  uart_in_ready,
    input  uart_out_data,
    input  uart_out_valid,
    output uart_out_ready
  );

  modport slave (
    input  uart_in_data,
    input  uart_in_valid,
    output uart_in_ready,
    output uart_out_data,
    output uart_out_valid,
    input  uart_out_ready
  );
endinterface

// File: rtl/usb_vec_bridge.sv
// Bridge between the USB-UART byte pipeline and two fabric bit vectors.
//   RX: each host byte b writes in_vec[b[7:1]] <= b[0]; 8'hFF clears in_vec;
//       an index >= IN_WIDTH is dropped and flagged on rx_err.
//   TX: snapshots out_vec, streams it as ASCII '0'/'1' per bit (bit 0 first),
//       then END_CHAR, then FRAME_GAP idle cycles, and repeats.
// Optional build macro USB_VEC_HEX_EN: TX emits hex nibbles ('0'-'9','A'-'F',
//   nibble 0 first) instead of one character per bit.
// Ports:
//   clk_48mhz, reset_n : clock, async active-low reset
//   uart               : byte pipelines (usb_vec_bridge_if.master)
//   out_vec            : vector reported to the host
//   in_vec             : host-written vector (registered)
//   in_update          : 1-cycle pulse when in_vec changed
//   rx_err             : 1-cycle pulse on out-of-range index byte
//   frame_done         : high on the cycle END_CHAR is accepted
module usb_vec_bridge #(
  parameter int unsigned IN_WIDTH  = 64,
  parameter int unsigned OUT_WIDTH = 64,
  parameter int unsigned FRAME_GAP = 0,
  parameter logic [7:0]  END_CHAR  = 8'h2A
) (
  input  logic                 clk_48mhz,
  input  logic                 reset_n,
  usb_vec_bridge_if.master     uart,
  input  logic [OUT_WIDTH-1:0] out_vec,
  output logic [IN_WIDTH-1:0]  in_vec,
  output logic                 in_update,
  output logic                 rx_err,
  output logic                 frame_done
);

`ifdef USB_VEC_HEX_EN
  localparam int unsigned NumChars = (OUT_WIDTH + 3) / 4;
  localparam int unsigned PadW     = 4 * NumChars;
`else
  localparam int unsigned NumChars = OUT_WIDTH;
`endif
  localparam int unsigned       CurW    = $clog2(OUT_WIDTH + 1);
  localparam logic [CurW-1:0]   CurLast = CurW'(NumChars - 1);
  localparam int unsigned       GapW    = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [GapW-1:0]   GapLast = GapW'(FRAME_GAP - 1);

  typedef enum logic [2:0] {StIdle, StSnap, StSend, StEnd, StGap} state_e;

  // ---------------------------------------------------------------- RX path
  logic [IN_WIDTH-1:0] in_vec_q, in_vec_d;
  logic                in_update_q, in_update_d;
  logic                rx_err_q, rx_err_d;
  logic                out_ready_q;
  logic                rx_fire;
  logic [6:0]          rx_idx;

  assign rx_fire = uart.uart_out_valid & out_ready_q;
  assign rx_idx  = uart.uart_out_data[7:1];

  always_comb begin
    in_vec_d    = in_vec_q;
    in_update_d = 1'b0;
    rx_err_d    = 1'b0;
    if (rx_fire) begin
      if (uart.uart_out_data == 8'hFF) begin
        in_vec_d = '0;
      end else if (32'(rx_idx) < IN_WIDTH) begin
        for (int unsigned i = 0; i < IN_WIDTH; i++) begin
          if (rx_idx == 7'(i)) in_vec_d[i] = uart.uart_out_data[0];
        end
      end else begin
        rx_err_d = 1'b1;
      end
      // Pulse only on an actual value change (covers both write and clear).
      in_update_d = (in_vec_d != in_vec_q);
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      in_vec_q    <= '0;
      in_update_q <= 1'b0;
      rx_err_q    <= 1'b0;
      out_ready_q <= 1'b0;
    end else begin
      in_vec_q    <= in_vec_d;
      in_update_q <= in_update_d;
      rx_err_q    <= rx_err_d;
      out_ready_q <= 1'b1;
    end
  end

  assign in_vec              = in_vec_q;
  assign in_update           = in_update_q;
  assign rx_err              = rx_err_q;
  assign uart.uart_out_ready = out_ready_q;

  // ---------------------------------------------------------------- TX path
  state_e               state_q, state_d;
  logic [CurW-1:0]      cursor_q, cursor_d;
  logic [OUT_WIDTH-1:0] snap_q, snap_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_fire;
  logic [7:0]           send_char;

`ifdef USB_VEC_HEX_EN
  logic [PadW-1:0] snap_pad;
  logic [3:0]      nib;
  assign snap_pad  = PadW'(snap_q);
  assign nib       = 4'(snap_pad >> {cursor_q, 2'b00});
  assign send_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
`else
  logic send_bit;
  assign send_bit  = 1'(snap_q >> cursor_q);
  assign send_char = 8'h30 + {7'h0, send_bit};
`endif

  assign tx_fire = tx_valid & uart.uart_in_ready;

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    snap_d   = snap_q;
    gap_d    = gap_q;
    case (state_q)
      StIdle: state_d = StSnap;
      StSnap: begin
        snap_d   = out_vec;
        cursor_d = '0;
        state_d  = StSend;
      end
      StSend: begin
        if (tx_fire) begin
          cursor_d = cursor_q + 1'b1;
          if (cursor_q == CurLast) state_d = StEnd;
        end
      end
      StEnd: begin
        if (tx_fire) begin
          if (FRAME_GAP == 0) begin
            state_d = StSnap;
          end else begin
            state_d = StGap;
            gap_d   = '0;
          end
        end
      end
      StGap: begin
        if (gap_q == GapLast) state_d = StSnap;
        else                  gap_d   = gap_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      cursor_q <= '0;
      snap_q   <= '0;
      gap_q    <= '0;
    end else begin
      cursor_q <= cursor_d;
      snap_q   <= snap_d;
      gap_q    <= gap_d;
    end
  end

  // Moore data/valid: stable while held; frame_done marks the terminator transfer.
  always_comb begin
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    frame_done = 1'b0;
    case (state_q)
      StSend: begin
        tx_valid = 1'b1;
        tx_data  = send_char;
      end
      StEnd: begin
        tx_valid   = 1'b1;
        tx_data    = END_CHAR;
        frame_done = uart.uart_in_ready;
      end
      default: ;
    endcase
  end

  assign uart.uart_in_valid = tx_valid;
  assign uart.uart_in_data  = tx_data;

endmodule

// File: tb/tb_usb_vec_bridge.sv
// Self-checking bench for usb_vec_bridge: two instances (8-bit out, no gap,
// 64-bit in; 10-bit out, 5-cycle gap, 5-bit in) checked every cycle against a
// frame/bit-vector reference model.
module tb_usb_vec_bridge;
  localparam int W0 = 8, W1 = 10, IW0 = 64, IW1 = 5, GAP0 = 0, GAP1 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  usb_vec_bridge_if bus0 ();
  usb_vec_bridge_if bus1 ();
  logic [W0-1:0]  out_vec0;
  logic [W1-1:0]  out_vec1;
  logic [IW0-1:0] in_vec0;
  logic [IW1-1:0] in_vec1;
  logic in_update0, rx_err0, frame_done0;
  logic in_update1, rx_err1, frame_done1;

  usb_vec_bridge #(.IN_WIDTH(IW0), .OUT_WIDTH(W0), .FRAME_GAP(GAP0), .END_CHAR(8'h2A)) u_dut0 (
    .clk_48mhz(clk), .reset_n(reset_n), .uart(bus0), .out_vec(out_vec0), .in_vec(in_vec0),
    .in_update(in_update0), .rx_err(rx_err0), .frame_done(frame_done0)
  );
  usb_vec_bridge #(.IN_WIDTH(IW1), .OUT_WIDTH(W1), .FRAME_GAP(GAP1), .END_CHAR(8'h2A)) u_dut1 (
    .clk_48mhz(clk), .reset_n(reset_n), .uart(bus1), .out_vec(out_vec1), .in_vec(in_vec1),
    .in_update(in_update1), .rx_err(rx_err1), .frame_done(frame_done1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0/1 per instance.
  int           pos[2];
  int           lowrun[2];
  int           explow[2];
  logic [15:0]  fval[2];
  logic         hold[2];
  logic [7:0]   hold_d[2];
  logic [127:0] exp_in[2];
  logic         pend_upd[2];
  logic         pend_err[2];
  logic         rx_rdy_exp;

  // Values applied at the next falling edge.
  logic          nx_rst, nx_rdy0, nx_rdy1, nx_rxv;
  logic [7:0]    nx_rxd;
  logic [W0-1:0] nx_vec0;
  logic [W1-1:0] nx_vec1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int nchars(input int w);
`ifdef USB_VEC_HEX_EN
    return (w + 3) / 4;
`else
    return w;
`endif
  endfunction

  function automatic logic [7:0] exp_byte(input logic [15:0] v, input int w, input int p);
    int nib;
    if (p == nchars(w)) return 8'h2A;
`ifdef USB_VEC_HEX_EN
    nib = int'((v >> (4 * p)) & 16'hF);
    return (nib < 10) ? 8'(48 + nib) : 8'(55 + nib);
`else
    nib = int'((v >> p) & 16'h1);
    return 8'(48 + nib);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pos[i] = 0; lowrun[i] = 0; explow[i] = 2; hold[i] = 1'b0; hold_d[i] = 8'h00;
      fval[i] = '0; exp_in[i] = '0; pend_upd[i] = 1'b0; pend_err[i] = 1'b0;
    end
    rx_rdy_exp = 1'b0;
  endtask

  task automatic rx_check(input int id, input logic [127:0] invec, input logic upd,
                          input logic err, input logic rdy, input int iw);
    int idx;
    chk($sformatf("rx_ready%0d", id), 128'(rdy), 128'(rx_rdy_exp));
    chk($sformatf("in_vec%0d", id), invec, exp_in[id]);
    chk($sformatf("rx_pulses%0d", id), 128'({upd, err}), 128'({pend_upd[id], pend_err[id]}));
    pend_upd[id] = 1'b0;
    pend_err[id] = 1'b0;
    if (rx_rdy_exp && nx_rxv) begin
      idx = int'(nx_rxd[7:1]);
      if (nx_rxd == 8'hFF) begin
        pend_upd[id] = (exp_in[id] != '0);
        exp_in[id]   = '0;
      end else if (idx < iw) begin
        pend_upd[id]    = (exp_in[id][idx] != nx_rxd[0]);
        exp_in[id][idx] = nx_rxd[0];
      end else begin
        pend_err[id] = 1'b1;
      end
    end
  endtask

  task automatic tx_check(input int id, input logic valid, input logic [7:0] data,
                          input logic ready, input logic fdone, input logic [15:0] vec,
                          input int w, input int gap);
    int   len;
    logic xfer;
    len = nchars(w) + 1;
    if (pos[id] == 0) fval[id] = vec;
    if (hold[id]) chk($sformatf("tx_hold%0d", id), 128'({valid, data}), 128'({1'b1, hold_d[id]}));
    if (!valid) begin
      chk($sformatf("tx_low_midframe%0d", id), 128'(pos[id]), 128'(0));
      lowrun[id]++;
    end else begin
      if (lowrun[id] != 0) chk($sformatf("tx_gap_len%0d", id), 128'(lowrun[id]), 128'(explow[id]));
      lowrun[id] = 0;
      chk($sformatf("tx_data%0d", id), 128'(data), 128'(exp_byte(fval[id], w, pos[id])));
    end
    xfer = valid && ready;
    chk($sformatf("frame_done%0d", id), 128'(fdone), 128'(xfer && (pos[id] == len - 1)));
    hold[id]   = valid && !ready;
    hold_d[id] = data;
    if (xfer) begin
      pos[id]++;
      if (pos[id] == len) begin
        pos[id]    = 0;
        explow[id] = gap + 1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    reset_n              = nx_rst;
    bus0.uart_in_ready   = nx_rdy0;
    bus1.uart_in_ready   = nx_rdy1;
    bus0.uart_out_valid  = nx_rxv;
    bus1.uart_out_valid  = nx_rxv;
    bus0.uart_out_data   = nx_rxd;
    bus1.uart_out_data   = nx_rxd;
    out_vec0             = nx_vec0;
    out_vec1             = nx_vec1;
    #1;
    if (!reset_n) begin
      chk("reset_outs0", 128'({bus0.uart_in_data, bus0.uart_in_valid, bus0.uart_out_ready,
                               in_vec0, in_update0, rx_err0, frame_done0}), '0);
      chk("reset_outs1", 128'({bus1.uart_in_data, bus1.uart_in_valid, bus1.uart_out_ready,
                               in_vec1, in_update1, rx_err1, frame_done1}), '0);
      model_reset();
    end else begin
      rx_check(0, 128'(in_vec0), in_update0, rx_err0, bus0.uart_out_ready, IW0);
      rx_check(1, 128'(in_vec1), in_update1, rx_err1, bus1.uart_out_ready, IW1);
      tx_check(0, bus0.uart_in_valid, bus0.uart_in_data, nx_rdy0, frame_done0,
               16'(out_vec0), W0, GAP0);
      tx_check(1, bus1.uart_in_valid, bus1.uart_in_data, nx_rdy1, frame_done1,
               16'(out_vec1), W1, GAP1);
      rx_rdy_exp = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] rx_seq [8];
    logic       chg0, chg1;
    int         k;
    rx_seq = '{8'h0B, 8'h0B, 8'h0A, 8'h0B, 8'hFE, 8'h09, 8'hFF, 8'hFF};
    model_reset();
    nx_rst = 1'b0; nx_rdy0 = 1'b1; nx_rdy1 = 1'b1; nx_rxv = 1'b1; nx_rxd = 8'h0B;
    nx_vec0 = 8'hA5; nx_vec1 = 10'h2C3;
    bus0.uart_in_ready = 1'b1; bus1.uart_in_ready = 1'b1;
    bus0.uart_out_valid = 1'b0; bus1.uart_out_valid = 1'b0;
    bus0.uart_out_data = 8'h00; bus1.uart_out_data = 8'h00;
    out_vec0 = 8'hA5; out_vec1 = 10'h2C3;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;

    // Held in reset with active inputs: everything stays zero.
    repeat (3) cycle();

    // Free-running frames, ready tied high.
    nx_rst = 1'b1; nx_rxv = 1'b0;
    repeat (40) cycle();

    // Directed RX bytes: set/repeat/clear bit, out-of-range, clear command.
    foreach (rx_seq[i]) begin
      nx_rxv = 1'b1; nx_rxd = rx_seq[i];
      cycle();
    end
    nx_rxv = 1'b0;
    repeat (2) cycle();

    // Ready 1-of-3 with out_vec cleared mid-frame.
    chg0 = 1'b0; chg1 = 1'b0;
    for (int i = 0; i < 150; i++) begin
      nx_rdy0 = (i % 3 == 0);
      nx_rdy1 = (i % 3 == 0);
      if (!chg0 && pos[0] == 1) begin nx_vec0 = '0; chg0 = 1'b1; end
      if (!chg1 && pos[1] == 1) begin nx_vec1 = '0; chg1 = 1'b1; end
      cycle();
    end

    // Random traffic on both pipelines; out_vec only changes mid-frame.
    for (int i = 0; i < 400; i++) begin
      nx_rdy0 = ($urandom_range(0, 3) != 0);
      nx_rdy1 = 1'($urandom_range(0, 1));
      nx_rxv  = 1'($urandom_range(0, 1));
      nx_rxd  = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      if (pos[0] >= 1 && $urandom_range(0, 7) == 0) nx_vec0 = 8'($urandom);
      if (pos[1] >= 1 && $urandom_range(0, 7) == 0) nx_vec1 = 10'($urandom);
      cycle();
    end

    // Reset in the middle of a frame, then restart from bit 0.
    nx_rdy0 = 1'b1; nx_rdy1 = 1'b1; nx_rxv = 1'b0; nx_vec0 = 8'h3C; nx_vec1 = 10'h2C3;
    k = 0;
    while (pos[0] != 1 && k < 100) begin
      cycle();
      k++;
    end
    chk("mid_send_reached", 128'(k < 100), 128'(1));
    nx_rst = 1'b0;
    repeat (2) cycle();
    nx_rst = 1'b1;
    repeat (60) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/usb_vec_bridge.md
Name: usb_vec_bridge

Overview:
Parametrised bridge between the USB-UART byte pipeline and two bit vectors exchanged with the fabric logic under test.
- RX side: decodes host bytes into single-bit writes of an IN_WIDTH-bit input vector.
- TX side: repeatedly snapshots an OUT_WIDTH-bit output vector and streams it as ASCII frames terminated by '*'.
- Successor to the ad-hoc top-level serialiser: adds width generics, a correct valid/ready handshake, a clear command, frame snapshotting, an inter-frame gap and status pulses.

Parameters:
IN_WIDTH, 64, width of host-written vector; legal range 1..127.
OUT_WIDTH, 64, width of reported vector; legal range 1..65535.
FRAME_GAP, 0, idle cycles inserted after each terminator byte before the next snapshot.
END_CHAR, 8'h2A, frame terminator byte ('*').

Ports:
clk_48mhz  input  1  system clock.
reset_n  input  1  asynchronous, active-low reset.
uart_in_data  output  8  byte to USB TX pipeline.
uart_in_valid  output  1  uart_in_data valid.
uart_in_ready  input  1  USB TX accepts byte.
uart_out_data  input  8  byte from USB RX pipeline.
uart_out_valid  input  1  uart_out_data valid.
uart_out_ready  output  1  bridge accepts byte.
out_vec  input  OUT_WIDTH  vector to report.
in_vec  output  IN_WIDTH  host-written vector (registered).
in_update  output  1  1-cycle pulse when in_vec changed value.
rx_err  output  1  1-cycle pulse on out-of-range index byte.
frame_done  output  1  1-cycle pulse on the cycle END_CHAR is accepted.

Behaviour:
Reset:
- Async assert, sync deassert handled upstream. While reset_n=0 all outputs are 0, FSM is in IDLE, cursor is 0.
- Reset mid-frame abandons the frame; no partial state survives.

Transfer rule: a byte moves only on a rising edge with valid&&ready high on both pipelines.

RX path:
- uart_out_ready is a flop: 0 in reset, 1 from the first clock after reset release. One byte is accepted per cycle.
- Accepted byte b with idx=b[7:1] and val=b[0]:
  - b==8'hFF: clear command. in_vec<=0. in_update pulses only if in_vec was nonzero.
  - idx<IN_WIDTH: in_vec[idx]<=val. in_update pulses only if the bit changed.
  - otherwise: byte dropped, rx_err pulses.
- Latency: in_vec and the pulses update on the edge that accepts the byte (visible the next cycle).

TX path FSM (IDLE, SNAP, SEND, END, GAP):
- IDLE -> SNAP on the first cycle after reset.
- SNAP: snap<=out_vec, cursor<=0, go to SEND.
- SEND: present uart_in_data=8'h30+snap[cursor] with uart_in_valid=1.
  - On transfer: cursor++. If cursor==OUT_WIDTH-1, go to END and present END_CHAR on the following cycle.
  - Data and valid are held stable while ready=0. Valid never drops without a transfer.
- END: present END_CHAR. On transfer, frame_done pulses and the FSM goes to GAP (or SNAP if FRAME_GAP==0).
- GAP: uart_in_valid=0 for exactly FRAME_GAP cycles (counter), then SNAP.
- Back-to-back: a byte can be presented on the cycle after a transfer, except for the single SNAP cycle per frame (valid=0 there).
- Frame length is OUT_WIDTH+1 bytes. out_vec changes during a frame do not affect that frame.
- Cursor width is $clog2(OUT_WIDTH+1). With OUT_WIDTH==1, SEND issues one byte then END.

Simultaneous events:
- RX and TX are independent. Both may transfer in the same cycle.
- in_vec writes never stall TX.

Optional Feature:
USB_VEC_HEX_EN: when defined, SEND emits hex nibbles instead of one character per bit.
- Nibble k = snap[4k+3:4k], zero-padded above OUT_WIDTH-1.
- Encoded as ASCII '0'-'9', 'A'-'F'.
- Frame is ceil(OUT_WIDTH/4) chars plus END_CHAR, nibble 0 first.
When undefined, the per-bit '0'/'1' encoding is used and no hex logic is built.

Test Plan:
- Reset then ready tied 1, OUT_WIDTH=8, out_vec=8'hA5 -> bytes 31,30,31,30,30,31,30,31,2A repeat; frame_done every 10th cycle (9 bytes + SNAP).
- uart_in_ready toggled 1-of-3 cycles, out_vec changed to 8'h00 mid-frame -> current frame still encodes A5; data stable whenever valid&&!ready; next frame is all 30.
- RX bytes 8'h0B, 8'h0B, 8'h0A (IN_WIDTH=64) -> in_vec[5]=1 then 0; in_update pulses twice (not on the repeated 0B).
- RX 8'hFE with IN_WIDTH=64 -> rx_err pulse, in_vec unchanged. Then 8'hFF with in_vec nonzero -> in_vec=0, in_update pulse.
- FRAME_GAP=5 -> exactly 5 valid-low cycles after each 2A, plus 1 SNAP cycle. reset_n pulsed low mid-SEND -> outputs 0 immediately; restart begins at bit 0.
- USB_VEC_HEX_EN, OUT_WIDTH=10, out_vec=10'h2C3 -> bytes 33,43,32,2A.
